// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared stall masks, bus FSM encodings and stall priority helper.
// Revision : 1.0
// ============================================================================
package pipe_ctrl_pkg;

    localparam logic [5:0]  c_STALL_NONE = 6'b000000;
    localparam logic [5:0]  c_STALL_ID   = 6'b000111;
    localparam logic [5:0]  c_STALL_EX   = 6'b001111;
    localparam logic [5:0]  c_STALL_MEM  = 6'b011111;

    localparam logic [1:0]  c_BUS_IDLE   = 2'd0;
    localparam logic [1:0]  c_BUS_WAIT   = 2'd1;
    localparam logic [1:0]  c_BUS_DONE   = 2'd2;

    localparam logic [31:0] c_ZERO_WORD  = 32'h0000_0000;

    // Flush beats every stall; deeper stages beat shallower ones.
    function automatic logic [5:0] stall_mask(input logic flush, input logic mem,
                                              input logic ex, input logic id);
        if (flush)    return c_STALL_NONE;
        else if (mem) return c_STALL_MEM;
        else if (ex)  return c_STALL_EX;
        else if (id)  return c_STALL_ID;
        else          return c_STALL_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_bus_wait_fsm.sv
`default_nettype none
// ============================================================================
// Module   : bus_wait_fsm
// Brief    : MEM-stage bus handshake sequencer with wait-cycle timeout.
// Revision : 1.0
// ============================================================================
module bus_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_mem_req,
    input  logic i_bus_ack,
    input  logic i_excp,
    output logic o_mem_stall,
    output logic o_bus_req,
    output logic o_bus_err
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_BUS_IDLE;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                c_BUS_IDLE: begin
                    if (i_mem_req && !i_excp) begin
                        r_state <= c_BUS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                c_BUS_WAIT: begin
                    // An exception abandons the transfer silently, even on the timeout cycle.
                    if (i_excp) begin
                        r_state <= c_BUS_IDLE;
                    end else if (i_bus_ack) begin
                        r_state <= c_BUS_DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state   <= c_BUS_IDLE;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_BUS_DONE: r_state <= c_BUS_IDLE;
                default:    r_state <= c_BUS_IDLE;
            endcase
        end
    end

    assign o_mem_stall = ((r_state == c_BUS_IDLE) && i_mem_req) ||
                         ((r_state == c_BUS_WAIT) && !i_bus_ack);
    assign o_bus_req   = (r_state == c_BUS_WAIT);
    assign o_bus_err   = r_bus_err;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Pipeline sequencer: stall merge, MEM bus handshake, exception flush.
// Revision : 1.0
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8,
    parameter int PERF_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id_i,
    input  logic              stallreq_ex_i,
    input  logic              mem_req_i,
    input  logic              bus_ack_i,
    input  logic              excp_i,
    input  logic [31:0]       excp_pc_i,
    output logic [5:0]        stall_o,
    output logic              bus_req_o,
    output logic              bus_err_o,
    output logic              flush_o,
    output logic [31:0]       new_pc_o,
    output logic [PERF_W-1:0] stall_cycles_o
);

    logic              w_mem_stall;
    logic [5:0]        w_stall;
    logic              r_flush;
    logic [31:0]       r_new_pc;
    logic [PERF_W-1:0] r_stall_cycles;

    bus_wait_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_bus_wait_fsm (
        .clk         (clk),
        .rst         (rst),
        .i_mem_req   (mem_req_i),
        .i_bus_ack   (bus_ack_i),
        .i_excp      (excp_i),
        .o_mem_stall (w_mem_stall),
        .o_bus_req   (bus_req_o),
        .o_bus_err   (bus_err_o)
    );

    assign w_stall = stall_mask(r_flush, w_mem_stall, stallreq_ex_i, stallreq_id_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush        <= 1'b0;
            r_new_pc       <= c_ZERO_WORD;
            r_stall_cycles <= '0;
        end else begin
            r_flush <= excp_i;
            if (excp_i) begin
                r_new_pc <= excp_pc_i;
            end
            if ((w_stall != c_STALL_NONE) && (r_stall_cycles != {PERF_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign stall_o        = w_stall;
    assign flush_o        = r_flush;
    assign new_pc_o       = r_new_pc;
    assign stall_cycles_o = r_stall_cycles;

endmodule
`default_nettype wire
